// File: rtl/ysyx_22050133_mul_ctrl_pkg.sv
// Shared encodings for the multiplier sequencer: RV64M op codes, multiplier
// signedness controls and the controller FSM states.
package ysyx_22050133_mul_ctrl_pkg;

   localparam logic [2:0] OP_MUL    = 3'd0;
   localparam logic [2:0] OP_MULH   = 3'd1;
   localparam logic [2:0] OP_MULHSU = 3'd2;
   localparam logic [2:0] OP_MULHU  = 3'd3;
   localparam logic [2:0] OP_MULW   = 3'd4;

   // bit 1: rs1 signed, bit 0: rs2 signed
   localparam logic [1:0] MUL_SIGNED_SS = 2'b11;
   localparam logic [1:0] MUL_SIGNED_SU = 2'b10;
   localparam logic [1:0] MUL_SIGNED_UU = 2'b00;

   typedef enum logic [1:0] {
      S_IDLE  = 2'd0,
      S_ISSUE = 2'd1,
      S_WAIT  = 2'd2,
      S_RESP  = 2'd3
   } state_e;

   function automatic logic op_reserved(input logic [2:0] op);
      return op > OP_MULW;
   endfunction

   function automatic logic [1:0] op_signed(input logic [2:0] op);
      case (op)
         OP_MULHSU: return MUL_SIGNED_SU;
         OP_MULHU:  return MUL_SIGNED_UU;
         default:   return MUL_SIGNED_SS;
      endcase
   endfunction

endpackage

// File: rtl/ysyx_22050133_mul_cache.sv
// One-entry result cache keyed by {src1, src2, signedness, mulw}; a MUL lookup
// also hits any non-MULW entry with equal operands since the low half ignores signedness.
module ysyx_22050133_mul_cache #(
   parameter int XLEN     = 64,
   parameter bit CACHE_EN = 1'b1
) (
   input  logic            clk,
   input  logic            rst,
   input  logic            inv,
   input  logic            wr_en,
   input  logic [XLEN-1:0] wr_src1,
   input  logic [XLEN-1:0] wr_src2,
   input  logic [1:0]      wr_signed,
   input  logic            wr_mulw,
   input  logic [XLEN-1:0] wr_hi,
   input  logic [XLEN-1:0] wr_lo,
   input  logic [XLEN-1:0] rd_src1,
   input  logic [XLEN-1:0] rd_src2,
   input  logic [1:0]      rd_signed,
   input  logic            rd_mulw,
   input  logic            rd_lo_only,
   output logic            hit,
   output logic [XLEN-1:0] hit_hi,
   output logic [XLEN-1:0] hit_lo
);

   logic            vld_q, vld_d;
   logic [XLEN-1:0] src1_q, src1_d, src2_q, src2_d, hi_q, hi_d, lo_q, lo_d;
   logic [1:0]      signed_q, signed_d;
   logic            mulw_q, mulw_d;

   always_comb begin
      vld_d    = vld_q;
      src1_d   = src1_q;
      src2_d   = src2_q;
      signed_d = signed_q;
      mulw_d   = mulw_q;
      hi_d     = hi_q;
      lo_d     = lo_q;
      if (inv) begin
         vld_d = 1'b0;
      end else if (wr_en) begin
         vld_d    = 1'b1;
         src1_d   = wr_src1;
         src2_d   = wr_src2;
         signed_d = wr_signed;
         mulw_d   = wr_mulw;
         hi_d     = wr_hi;
         lo_d     = wr_lo;
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         vld_q    <= 1'b0;
         src1_q   <= '0;
         src2_q   <= '0;
         signed_q <= '0;
         mulw_q   <= 1'b0;
         hi_q     <= '0;
         lo_q     <= '0;
      end else begin
         vld_q    <= vld_d;
         src1_q   <= src1_d;
         src2_q   <= src2_d;
         signed_q <= signed_d;
         mulw_q   <= mulw_d;
         hi_q     <= hi_d;
         lo_q     <= lo_d;
      end
   end

   logic ops_match;
   assign ops_match = vld_q && (src1_q == rd_src1) && (src2_q == rd_src2);
   assign hit       = CACHE_EN && ops_match &&
                      (((signed_q == rd_signed) && (mulw_q == rd_mulw)) || (rd_lo_only && !mulw_q));
   assign hit_hi    = hi_q;
   assign hit_lo    = lo_q;

endmodule

// File: rtl/ysyx_22050133_mul_ctrl.sv
// Sequencer between EXU and the iterative multiplier: issues ops, selects the
// result, serves MULH*->MUL repeats from a one-entry cache and forwards flush.
module ysyx_22050133_mul_ctrl
   import ysyx_22050133_mul_ctrl_pkg::*;
#(
   parameter int XLEN     = 64,
   parameter bit CACHE_EN = 1'b1,
   parameter int LAT_W    = 16
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             flush,
   input  logic             in_valid,
   output logic             in_ready,
   input  logic [2:0]       in_op,
   input  logic [XLEN-1:0]  in_src1,
   input  logic [XLEN-1:0]  in_src2,
   output logic             out_valid,
   input  logic             out_ready,
   output logic [XLEN-1:0]  out_data,
   output logic             out_hit,
   output logic             m_valid,
   input  logic             m_ready,
   output logic             m_mulw,
   output logic [1:0]       m_signed,
   output logic [XLEN-1:0]  m_multiplicand,
   output logic [XLEN-1:0]  m_multiplier,
   output logic             m_flush,
   input  logic             m_out_valid,
   input  logic [XLEN-1:0]  m_result_hi,
   input  logic [XLEN-1:0]  m_result_lo,
   output logic [LAT_W-1:0] perf_last_lat
);

   state_e           state_q, state_d;
   logic [2:0]       op_q, op_d;
   logic [XLEN-1:0]  mcand_q, mcand_d, mplier_q, mplier_d, out_data_q, out_data_d;
   logic [1:0]       signed_q, signed_d;
   logic             mulw_q, mulw_d, hit_q, hit_d;
   logic [LAT_W-1:0] lat_q, lat_d, perf_q, perf_d, lat_inc;

   logic            c_hit, c_wr;
   logic [XLEN-1:0] c_hi, c_lo;

   function automatic logic [XLEN-1:0] sel_result(input logic [2:0] op,
                                                  input logic [XLEN-1:0] hi,
                                                  input logic [XLEN-1:0] lo);
      if (op == OP_MUL)  return lo;
      if (op == OP_MULW) return {{(XLEN-32){lo[31]}}, lo[31:0]};
      return hi;
   endfunction

   assign c_wr = (state_q == S_WAIT) && m_out_valid && !flush && !mulw_q;

   ysyx_22050133_mul_cache #(.XLEN(XLEN), .CACHE_EN(CACHE_EN)) u_cache (
      .clk        (clk),
      .rst        (rst),
      .inv        (flush),
      .wr_en      (c_wr),
      .wr_src1    (mcand_q),
      .wr_src2    (mplier_q),
      .wr_signed  (signed_q),
      .wr_mulw    (mulw_q),
      .wr_hi      (m_result_hi),
      .wr_lo      (m_result_lo),
      .rd_src1    (in_src1),
      .rd_src2    (in_src2),
      .rd_signed  (op_signed(in_op)),
      .rd_mulw    (in_op == OP_MULW),
      .rd_lo_only (in_op == OP_MUL),
      .hit        (c_hit),
      .hit_hi     (c_hi),
      .hit_lo     (c_lo)
   );

   assign in_ready  = (state_q == S_IDLE) && !flush && !rst;
   // Counter starts at 1 on accept so a cache hit reports a latency of one cycle.
   assign lat_inc   = (lat_q == {LAT_W{1'b1}}) ? lat_q : lat_q + LAT_W'(1);

   always_comb begin
      state_d    = state_q;
      op_d       = op_q;
      mcand_d    = mcand_q;
      mplier_d   = mplier_q;
      signed_d   = signed_q;
      mulw_d     = mulw_q;
      hit_d      = hit_q;
      out_data_d = out_data_q;
      lat_d      = lat_q;
      perf_d     = perf_q;
      unique case (state_q)
         S_IDLE: begin
            if (in_valid && in_ready) begin
               op_d     = in_op;
               mcand_d  = in_src1;
               mplier_d = in_src2;
               signed_d = op_signed(in_op);
               mulw_d   = (in_op == OP_MULW);
               lat_d    = LAT_W'(1);
               hit_d    = 1'b0;
               if (op_reserved(in_op)) begin
                  out_data_d = '0;
                  state_d    = S_RESP;
               end else if (c_hit) begin
                  out_data_d = sel_result(in_op, c_hi, c_lo);
                  hit_d      = 1'b1;
                  state_d    = S_RESP;
               end else begin
                  state_d = S_ISSUE;
               end
            end
         end
         S_ISSUE: begin
            lat_d = lat_inc;
            if (m_ready) state_d = S_WAIT;
         end
         S_WAIT: begin
            lat_d = lat_inc;
            if (m_out_valid) begin
               out_data_d = sel_result(op_q, m_result_hi, m_result_lo);
               state_d    = S_RESP;
            end
         end
         S_RESP: begin
            if (out_ready) begin
               perf_d  = lat_q;
               state_d = S_IDLE;
            end
         end
      endcase
      // A flushed response counts as dropped, so it does not update the latency stat.
      if (flush) begin
         state_d = S_IDLE;
         perf_d  = perf_q;
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q    <= S_IDLE;
         op_q       <= '0;
         mcand_q    <= '0;
         mplier_q   <= '0;
         signed_q   <= '0;
         mulw_q     <= 1'b0;
         hit_q      <= 1'b0;
         out_data_q <= '0;
         lat_q      <= '0;
         perf_q     <= '0;
      end else begin
         state_q    <= state_d;
         op_q       <= op_d;
         mcand_q    <= mcand_d;
         mplier_q   <= mplier_d;
         signed_q   <= signed_d;
         mulw_q     <= mulw_d;
         hit_q      <= hit_d;
         out_data_q <= out_data_d;
         lat_q      <= lat_d;
         perf_q     <= perf_d;
      end
   end

   assign out_valid      = (state_q == S_RESP);
   assign out_data       = out_data_q;
   assign out_hit        = hit_q;
   assign m_valid        = (state_q == S_ISSUE);
   assign m_mulw         = mulw_q;
   assign m_signed       = signed_q;
   assign m_multiplicand = mcand_q;
   assign m_multiplier   = mplier_q;
   assign m_flush        = flush && ((state_q == S_ISSUE) || (state_q == S_WAIT));
   assign perf_last_lat  = perf_q;

endmodule

// File: tb/tb_ysyx_22050133_mul_ctrl.sv
// Directed bench for the multiplier sequencer with a behavioural iterative multiplier.
module tb_ysyx_22050133_mul_ctrl;
   localparam int MLAT = 5;
   localparam logic [63:0] ONES = 64'hFFFF_FFFF_FFFF_FFFF;

   logic        clk = 1'b0;
   logic        rst, flush, in_valid, in_ready, out_valid, out_ready, out_hit;
   logic        m_valid, m_ready, m_mulw, m_flush, m_out_valid;
   logic [2:0]  in_op;
   logic [63:0] in_src1, in_src2, out_data, m_multiplicand, m_multiplier, m_result_hi, m_result_lo;
   logic [1:0]  m_signed;
   logic [15:0] perf_last_lat;

   always #5 clk = ~clk;

   ysyx_22050133_mul_ctrl dut (
      .clk(clk), .rst(rst), .flush(flush),
      .in_valid(in_valid), .in_ready(in_ready), .in_op(in_op),
      .in_src1(in_src1), .in_src2(in_src2),
      .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data), .out_hit(out_hit),
      .m_valid(m_valid), .m_ready(m_ready), .m_mulw(m_mulw), .m_signed(m_signed),
      .m_multiplicand(m_multiplicand), .m_multiplier(m_multiplier), .m_flush(m_flush),
      .m_out_valid(m_out_valid), .m_result_hi(m_result_hi), .m_result_lo(m_result_lo),
      .perf_last_lat(perf_last_lat)
   );

   function automatic logic [127:0] full_prod(input logic [63:0] a, input logic [63:0] b,
                                              input logic [1:0] s);
      logic [127:0] ea, eb;
      ea = s[1] ? {{64{a[63]}}, a} : {64'b0, a};
      eb = s[0] ? {{64{b[63]}}, b} : {64'b0, b};
      return ea * eb;
   endfunction

   function automatic logic [63:0] ref_res(input logic [2:0] op, input logic [63:0] a,
                                           input logic [63:0] b);
      logic [127:0] p;
      case (op)
         3'd0: begin p = full_prod(a, b, 2'b11); return p[63:0];   end
         3'd1: begin p = full_prod(a, b, 2'b11); return p[127:64]; end
         3'd2: begin p = full_prod(a, b, 2'b10); return p[127:64]; end
         3'd3: begin p = full_prod(a, b, 2'b00); return p[127:64]; end
         3'd4: begin p = full_prod(a, b, 2'b11); return {{32{p[31]}}, p[31:0]}; end
         default: return 64'd0;
      endcase
   endfunction

   // Behavioural iterative multiplier: level out_valid, cleared on accept or flush.
   logic         busy, rdy_en;
   int           cnt;
   logic [127:0] p_l;
   assign m_ready = !busy && rdy_en;
   always @(posedge clk) begin
      if (rst) begin
         busy <= 1'b0; cnt <= 0; m_out_valid <= 1'b0;
         m_result_hi <= '0; m_result_lo <= '0; p_l <= '0;
      end else if (m_flush) begin
         busy <= 1'b0; m_out_valid <= 1'b0;
      end else if (m_valid && m_ready) begin
         busy <= 1'b1; cnt <= MLAT; m_out_valid <= 1'b0;
         p_l  <= m_mulw ? {{96{m_multiplicand[31] ^ m_multiplier[31]}}, 32'h0} |
                          {64'h0, full_prod({{32{m_multiplicand[31]}}, m_multiplicand[31:0]},
                                            {{32{m_multiplier[31]}}, m_multiplier[31:0]}, 2'b11)}
                        : full_prod(m_multiplicand, m_multiplier, m_signed);
      end else if (busy) begin
         if (cnt == 0) begin
            busy <= 1'b0; m_out_valid <= 1'b1;
            m_result_hi <= p_l[127:64]; m_result_lo <= p_l[63:0];
         end else begin
            cnt <= cnt - 1;
         end
      end
   end

   int mv_cnt = 0;
   always @(posedge clk) if (m_valid) mv_cnt <= mv_cnt + 1;

   typedef struct { logic [63:0] data; logic hit; } exp_t;
   exp_t sb[$];
   int n_cmp = 0, n_bad = 0;

   logic        cv;
   logic [63:0] ca, cb;
   logic [1:0]  cs;

   task automatic step();
      @(posedge clk); #1;
   endtask

   task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      n_cmp++;
      assert (obs === exp) else begin
         n_bad++;
         $error("FAIL %s: observed %h expected %h", tag, obs, exp);
      end
   endtask

   task automatic push_exp(input logic [2:0] op, input logic [63:0] a, input logic [63:0] b);
      exp_t e;
      logic [1:0] s;
      e.data = ref_res(op, a, b);
      e.hit  = 1'b0;
      if (op <= 3'd4) begin
         s = (op == 3'd2) ? 2'b10 : (op == 3'd3) ? 2'b00 : 2'b11;
         e.hit = cv && ca == a && cb == b && op != 3'd4 && (cs == s || op == 3'd0);
         if (!e.hit && op != 3'd4) begin cv = 1'b1; ca = a; cb = b; cs = s; end
      end
      sb.push_back(e);
   endtask

   task automatic issue(input logic [2:0] op, input logic [63:0] a, input logic [63:0] b);
      int n;
      in_valid = 1'b1; in_op = op; in_src1 = a; in_src2 = b;
      n = 0;
      while (!in_ready && n < 50) begin step(); n++; end
      chk("accept_timeout", 64'(n < 50), 64'd1);
      step();
      in_valid = 1'b0;
   endtask

   task automatic do_op(input logic [2:0] op, input logic [63:0] a, input logic [63:0] b,
                        input int stall, output logic [63:0] got, output logic got_hit);
      exp_t e;
      int n, held;
      push_exp(op, a, b);
      issue(op, a, b);
      if (stall > 0) begin
         held = 0;
         repeat (stall) begin if (m_valid === 1'b1) held++; step(); end
         chk("issue_hold", 64'(held), 64'(stall));
         rdy_en = 1'b1;
      end
      n = 0;
      while (!out_valid && n < 200) begin step(); n++; end
      chk("resp_timeout", 64'(n < 200), 64'd1);
      got = out_data; got_hit = out_hit;
      e = sb.pop_front();
      chk("sb_data", got, e.data);
      chk("sb_hit", 64'(got_hit), 64'(e.hit));
      if (out_ready) step();
   endtask

   task automatic chk_reset(input string tag);
      chk({tag, "_in_ready"}, 64'(in_ready), 64'd0);
      chk({tag, "_out_valid"}, 64'(out_valid), 64'd0);
      chk({tag, "_out_hit"}, 64'(out_hit), 64'd0);
      chk({tag, "_m_valid"}, 64'(m_valid), 64'd0);
      chk({tag, "_m_mulw"}, 64'(m_mulw), 64'd0);
      chk({tag, "_m_flush"}, 64'(m_flush), 64'd0);
      chk({tag, "_m_signed"}, 64'(m_signed), 64'd0);
      chk({tag, "_m_mcand"}, m_multiplicand, 64'd0);
      chk({tag, "_m_mplier"}, m_multiplier, 64'd0);
      chk({tag, "_out_data"}, out_data, 64'd0);
      chk({tag, "_perf"}, 64'(perf_last_lat), 64'd0);
   endtask

   initial begin
      logic [63:0] d, d0;
      logic        h, seen, stable;
      logic [63:0] av [3];
      logic [63:0] bv [2];
      int          n, mv0;
      av[0] = 64'd3; av[1] = ONES; av[2] = 64'd5;
      bv[0] = 64'd2; bv[1] = 64'hFFFF_FFFF_FFFF_FFF9;
      rst = 1'b1; flush = 1'b0; in_valid = 1'b0; in_op = '0; in_src1 = '0; in_src2 = '0;
      out_ready = 1'b1; rdy_en = 1'b1; cv = 1'b0; ca = '0; cb = '0; cs = '0;
      step(); step();
      chk_reset("rst0");
      rst = 1'b0;
      step();
      chk("idle_in_ready", 64'(in_ready), 64'd1);

      // MULH then MUL on the same operands: the second is a cache hit
      do_op(3'd1, ONES, 64'd2, 0, d, h);
      chk("mulh_data", d, ONES);
      chk("mulh_hit", 64'(h), 64'd0);
      mv0 = mv_cnt;
      do_op(3'd0, ONES, 64'd2, 0, d, h);
      chk("mul_hit_data", d, 64'hFFFF_FFFF_FFFF_FFFE);
      chk("mul_hit_hit", 64'(h), 64'd1);
      chk("mul_hit_no_issue", 64'(mv_cnt - mv0), 64'd0);
      chk("mul_hit_lat", 64'(perf_last_lat), 64'd1);

      do_op(3'd4, 64'h7FFF_FFFF, 64'd2, 0, d, h);
      chk("mulw_data", d, 64'hFFFF_FFFF_FFFF_FFFE);
      do_op(3'd3, ONES, ONES, 0, d, h);
      chk("mulhu_data", d, 64'hFFFF_FFFF_FFFF_FFFE);
      do_op(3'd2, ONES, 64'd2, 0, d, h);
      chk("mulhsu_data", d, ONES);
      do_op(3'd3, ONES, 64'd2, 0, d, h);
      chk("mulhu_after_su_data", d, 64'd1);
      chk("mulhu_after_su_hit", 64'(h), 64'd0);

      mv0 = mv_cnt;
      do_op(3'd6, 64'd9, 64'd9, 0, d, h);
      chk("reserved_data", d, 64'd0);
      chk("reserved_no_issue", 64'(mv_cnt - mv0), 64'd0);

      rdy_en = 1'b0;
      do_op(3'd0, 64'd21, 64'd2, 3, d, h);
      chk("stall_mul_data", d, 64'd42);

      for (int i = 0; i < 8; i++)
         do_op(3'($urandom_range(0, 4)), av[$urandom_range(0, 2)], bv[$urandom_range(0, 1)], 0, d, h);

      // flush three cycles into WAIT
      issue(3'd1, 64'd123, 64'd456);
      n = 0;
      while (m_valid && n < 20) begin step(); n++; end
      step(); step();
      flush = 1'b1; #1;
      chk("flush_m_flush", 64'(m_flush), 64'd1);
      chk("flush_in_ready", 64'(in_ready), 64'd0);
      @(posedge clk); #1;
      flush = 1'b0;
      seen = 1'b0;
      repeat (12) begin if (out_valid) seen = 1'b1; step(); end
      chk("flush_no_resp", 64'(seen), 64'd0);
      do_op(3'd0, 64'd3, 64'd5, 0, d, h);
      chk("post_flush_data", d, 64'd15);
      chk("post_flush_hit", 64'(h), 64'd0);

      // response held while out_ready is low
      out_ready = 1'b0;
      do_op(3'd2, 64'd5, 64'hFFFF_FFFF_FFFF_FFFD, 0, d0, h);
      stable = 1'b1;
      repeat (5) begin
         step();
         if (!(out_valid === 1'b1 && out_data === d0 && in_ready === 1'b0)) stable = 1'b0;
      end
      chk("resp_hold_stable", 64'(stable), 64'd1);
      out_ready = 1'b1;
      step();
      chk("resp_released", 64'(out_valid), 64'd0);

      // reset mid-WAIT drops everything including the cache
      do_op(3'd3, 64'd7, 64'd9, 0, d, h);
      issue(3'd1, 64'd11, 64'd13);
      n = 0;
      while (m_valid && n < 20) begin step(); n++; end
      step();
      rst = 1'b1;
      step();
      chk_reset("rst_wait");
      rst = 1'b0; cv = 1'b0;
      step();
      do_op(3'd3, 64'd7, 64'd9, 0, d, h);
      chk("post_rst_miss", 64'(h), 64'd0);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

   initial begin
      #200000;
      $display("FAIL global_timeout: simulation did not complete");
      $fatal(1, "timeout");
   end
endmodule
